// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: FSM state and next-PC select encodings shared by the
// pipeline hazard controller.
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALT} state_t;
   localparam logic [1:0] PC_SEL_SEQ = 2'b00;
   localparam logic [1:0] PC_SEL_BR  = 2'b01;
   localparam logic [1:0] PC_SEL_JMP = 2'b10;
endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// load_use_detect: flags an ID instruction that reads the register an EX load
// is about to write (r0 never hazards).
module load_use_detect (
   input  logic       ex_memread_i,
   input  logic [4:0] ex_rt_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   output logic       loaduse_o
);
   assign loaduse_o = ex_memread_i & (ex_rt_i != 5'd0) &
                      ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: PC/IF-ID/ID-EX sequencing with load-use, redirect, memory-wait
// and timeout handling. PIPELINE_CTRL_STALL_CNT_EN enables the stall counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rt_i,
   input  logic        id_branch_taken_i,
   input  logic        id_jump_i,
   input  logic        dmem_req_i,
   input  logic        dmem_ack_i,
   output logic        pc_write_o,
   output logic [1:0]  pc_sel_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        pipe_hold_o,
   output logic        err_o,
   output logic [31:0] stall_cnt_o
);
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 2);
   state_t     r_state, w_next;
   logic [7:0] r_tmo;
   logic       w_loaduse, w_memstall, w_frozen, w_go, w_redirect;
   load_use_detect u_lud (
      .ex_memread_i(ex_memread_i),
      .ex_rt_i     (ex_rt_i),
      .id_rs_i     (id_rs_i),
      .id_rt_i     (id_rt_i),
      .loaduse_o   (w_loaduse)
   );
   assign w_memstall = dmem_req_i & ~dmem_ack_i;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_tmo   <= '0;
      end else begin
         r_state <= w_next;
         r_tmo   <= (r_state == MEM_WAIT && !dmem_ack_i) ? r_tmo + 8'd1 : 8'd0;
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     w_next = start_i ? RUN : IDLE;
         RUN:      w_next = w_memstall ? MEM_WAIT : (start_i ? RUN : IDLE);
         MEM_WAIT: w_next = dmem_ack_i ? RUN : (r_tmo == TMO_LAST ? HALT : MEM_WAIT);
         default:  w_next = HALT;
      endcase
   end
   // A cycle either freezes the whole core or falls through to the RUN priorities.
   always_comb begin
      w_frozen      = (r_state == IDLE) | (r_state == HALT) |
                      (r_state == RUN & w_memstall) | (r_state == MEM_WAIT & ~dmem_ack_i);
      w_go          = ~w_frozen & ~w_loaduse;
      w_redirect    = id_jump_i | id_branch_taken_i;
      pc_write_o    = w_go;
      pc_sel_o      = !w_go ? PC_SEL_SEQ : id_jump_i ? PC_SEL_JMP :
                      id_branch_taken_i ? PC_SEL_BR : PC_SEL_SEQ;
      ifid_write_o  = w_go & ~w_redirect;
      ifid_flush_o  = w_go & w_redirect;
      idex_bubble_o = ~w_frozen & w_loaduse;
      pipe_hold_o   = w_frozen;
      err_o         = (r_state == HALT);
   end
`ifdef PIPELINE_CTRL_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_stall_cnt <= '0;
      else if ((r_state == RUN || r_state == MEM_WAIT) && !pc_write_o && !(&r_stall_cnt))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end
   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus with a cycle-level behavioural model of
// the hazard controller, checked every negedge, plus literal spot checks.
module tb_pipeline_ctrl;
   localparam int MEM_TIMEOUT = 4;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   logic        clk = 0, rst_i = 1, start_i = 0;
   logic [4:0]  id_rs_i = 0, id_rt_i = 0, ex_rt_i = 0;
   logic        ex_memread_i = 0, id_branch_taken_i = 0, id_jump_i = 0;
   logic        dmem_req_i = 0, dmem_ack_i = 0;
   logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, err_o;
   logic [1:0]  pc_sel_o;
   logic [31:0] stall_cnt_o;
   int errors = 0, checks = 0;
   bit m_valid = 0, m_on = 0, m_wait = 0, m_halt = 0;
   int m_miss = 0;
   logic [31:0] m_stall = 0;

   pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
      .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i),
      .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_write_o(pc_write_o), .pc_sel_o(pc_sel_o),
      .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
      .idex_bubble_o(idex_bubble_o), .pipe_hold_o(pipe_hold_o),
      .err_o(err_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   // {pc_write, pc_sel[1:0], ifid_write, ifid_flush, idex_bubble, pipe_hold, err}
   function automatic logic [7:0] exp_outs();
      logic lu, ms, frz;
      lu  = ex_memread_i && ex_rt_i != 0 && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
      ms  = dmem_req_i && !dmem_ack_i;
      frz = m_halt || (!m_on && !m_wait) || (m_on && ms) || (m_wait && !dmem_ack_i);
      if (frz)               return {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, m_halt};
      if (lu)                return {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      if (id_jump_i)         return {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      if (id_branch_taken_i) return {1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      return {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   endfunction

   always @(posedge clk) begin
      logic [7:0] e;
      e = exp_outs();
      if (rst_i) begin
         m_valid = 1; m_on = 0; m_wait = 0; m_halt = 0; m_miss = 0; m_stall = 0;
      end else begin
         if ((m_on || m_wait) && !e[7] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (m_halt) begin
         end else if (m_wait) begin
            if (dmem_ack_i) begin
               m_wait = 0; m_on = 1; m_miss = 0;
            end else begin
               m_miss = m_miss + 1;
               if (m_miss == MEM_TIMEOUT) begin m_wait = 0; m_halt = 1; end
            end
         end else if (m_on && dmem_req_i && !dmem_ack_i) begin
            m_on = 0; m_wait = 1; m_miss = 1;
         end else m_on = start_i;
      end
   end

   always @(negedge clk) begin
      logic [7:0] got, e;
      logic [31:0] es;
      if (m_valid) begin
         got = {pc_write_o, pc_sel_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, err_o};
         e   = exp_outs();
         es  = CNT_EN ? m_stall : 32'd0;
         checks = checks + 2;
         if (got !== e) begin
            errors = errors + 1;
            $display("FAIL model_outs t=%0t got=%b exp=%b", $time, got, e);
         end
         if (stall_cnt_o !== es) begin
            errors = errors + 1;
            $display("FAIL model_stall t=%0t got=%0d exp=%0d", $time, stall_cnt_o, es);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   initial begin
      tick(); tick();
      chk("reset_idle", {pc_write_o, ifid_write_o, pipe_hold_o, err_o, stall_cnt_o != 0}, 5'b00100);
      rst_i = 0; start_i = 1; tick();
      chk("start_run", {pc_write_o, pc_sel_o, ifid_write_o}, 4'b1001);
      ex_memread_i = 1; ex_rt_i = 5; id_rs_i = 5; tick();
      chk("loaduse_stall", {pc_write_o, ifid_write_o, idex_bubble_o}, 3'b001);
      ex_memread_i = 0; tick();
      chk("loaduse_one_cycle", {pc_write_o, idex_bubble_o}, 2'b10);
      dmem_req_i = 1; tick();
      chk("mem_hold1", pipe_hold_o, 1);
      tick(); chk("mem_hold2", pipe_hold_o, 1);
      tick(); chk("mem_hold3", pipe_hold_o, 1);
      dmem_ack_i = 1; tick();
      chk("mem_ack_normal", {pipe_hold_o, pc_write_o, ifid_write_o}, 3'b011);
      dmem_req_i = 0; dmem_ack_i = 0; tick();
      chk("stall_cnt_4", stall_cnt_o, CNT_EN ? 32'd4 : 32'd0);
      ex_memread_i = 1; ex_rt_i = 0; id_rs_i = 0; tick();
      chk("rt_zero_no_stall", {pc_write_o, idex_bubble_o}, 2'b10);
      ex_memread_i = 0; id_jump_i = 1; id_branch_taken_i = 1; tick();
      chk("jump_wins", {pc_write_o, pc_sel_o, ifid_flush_o}, 4'b1101);
      ex_memread_i = 1; ex_rt_i = 7; id_rt_i = 7; tick();
      chk("stall_beats_redirect", {pc_write_o, ifid_flush_o, idex_bubble_o}, 3'b001);
      ex_memread_i = 0; id_jump_i = 0; tick();
      chk("branch_sel", {pc_sel_o, ifid_flush_o}, 3'b011);
      id_branch_taken_i = 0; start_i = 0; tick();
      chk("stop_idle", {pc_write_o, pipe_hold_o}, 2'b01);
      start_i = 1; tick();
      chk("restart", pc_write_o, 1);
      dmem_req_i = 1; tick(); tick(); tick();
      chk("pre_timeout", err_o, 0);
      tick();
      chk("timeout_halt", {err_o, pipe_hold_o, pc_write_o}, 3'b110);
      dmem_req_i = 0; start_i = 0; tick();
      chk("halt_sticky", err_o, 1);
      rst_i = 1; tick();
      chk("reset_from_halt", {err_o, pc_write_o, pipe_hold_o}, 3'b001);
      rst_i = 0; tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipelined CPU. It owns the program counter's write enable and next-PC select, the IF/ID write and flush, and the ID/EX bubble. It resolves load-use hazards, branch and jump redirects, and data-memory wait states, and halts the core on a memory-ack timeout. It sits beside the PC register and the pipeline registers, and its outputs drive their enables directly.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent in MEM_WAIT before the core halts; legal range 2..255.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: core run enable.
- `id_rs_i`, `id_rt_i` in 5: source register numbers of the instruction in ID.
- `ex_memread_i` in 1: the instruction in EX is a load.
- `ex_rt_i` in 5: destination register of the EX load.
- `id_branch_taken_i` in 1: a branch resolved as taken in ID.
- `id_jump_i` in 1: the instruction in ID is a jump.
- `dmem_req_i` in 1: the MEM stage is accessing data memory.
- `dmem_ack_i` in 1: data memory has completed the access.
- `pc_write_o` out 1: PC load enable.
- `pc_sel_o` out 2: next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target.
- `ifid_write_o` out 1: IF/ID register write enable.
- `ifid_flush_o` out 1: IF/ID register is cleared to a NOP.
- `idex_bubble_o` out 1: ID/EX control fields are zeroed.
- `pipe_hold_o` out 1: ID/EX, EX/MEM and MEM/WB registers are frozen.
- `err_o` out 1: sticky memory-timeout flag.
- `stall_cnt_o` out 32: stall-cycle counter.

## Operation
- Registered FSM with states IDLE, RUN, MEM_WAIT, HALT. All outputs are combinational from the state and the current inputs.
- Signal definitions used below:
  - memstall = `dmem_req_i` & ~`dmem_ack_i`.
  - loaduse = `ex_memread_i` & (`ex_rt_i` != 0) & (`ex_rt_i` == `id_rs_i` | `ex_rt_i` == `id_rt_i`).
- IDLE:
  - Outputs: `pc_write_o`=0, `ifid_write_o`=0, `pipe_hold_o`=1, other outputs 0.
  - Transition: `start_i`=1 → RUN.
- RUN, evaluated by priority:
  1. memstall: freeze everything (`pc_write_o`=0, `ifid_write_o`=0, `pipe_hold_o`=1, no bubble, no flush); next state MEM_WAIT.
  2. loaduse: `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1; stay in RUN.
  3. `id_jump_i`: `pc_write_o`=1, `pc_sel_o`=10, `ifid_flush_o`=1.
  4. `id_branch_taken_i`: `pc_write_o`=1, `pc_sel_o`=01, `ifid_flush_o`=1.
  5. Otherwise: `pc_write_o`=1, `ifid_write_o`=1, `pc_sel_o`=00.
  - `start_i`=0 with no memstall → IDLE next cycle. This cycle still uses the RUN outputs above.
- MEM_WAIT:
  - Freeze everything while `dmem_ack_i`=0; the timeout counter increments each cycle.
  - `dmem_ack_i`=1: outputs follow RUN priorities 2–5; next state RUN; counter cleared.
  - Counter reaches `MEM_TIMEOUT`-1 with `dmem_ack_i`=0: next state HALT, `err_o` set.
- HALT: freeze everything and hold `err_o`=1 until `rst_i`.
- Simultaneous events:
  - Jump and taken branch together: the jump wins.
  - Load-use and redirect together: the stall wins; the redirect is re-evaluated next cycle from the held ID.

## Timing
- Reset, taken at the clock edge while `rst_i`=1: state=IDLE, timeout counter=0, `err_o`=0, `stall_cnt_o`=0.
  - Resulting outputs: `pc_write_o`=0, `ifid_write_o`=0, `pipe_hold_o`=1, all others 0.
- Reset mid-operation (including during MEM_WAIT or HALT) takes effect at the next edge.
- From `start_i` sampled high, `pc_write_o`=1 on the next cycle at the earliest.
- Load-use costs exactly one stall cycle.
- A redirect takes effect in the same cycle: PC loads the target at the next edge.
- Memory stall lasts N cycles for an ack arriving N cycles after the request.
- Timeout: HALT is entered after `MEM_TIMEOUT` consecutive unacknowledged cycles (one RUN cycle plus `MEM_TIMEOUT`-1 MEM_WAIT cycles).

## Configuration
- `PIPELINE_CTRL_STALL_CNT_EN` defined:
  - `stall_cnt_o` increments every cycle in RUN or MEM_WAIT where `pc_write_o`=0.
  - It saturates at 32'hFFFFFFFF and clears only on reset.
- Not defined: `stall_cnt_o` is tied to 0 and no counter logic is generated.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/MEM_WAIT/HALT);
  - the `pc_sel` encodings (PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_JMP=2'b10).
- One sub-module, `load_use_detect`: combinational hazard compare producing loaduse.
- The FSM, timeout counter and stall counter live in the top module.

## Test plan
- Reset then `start_i`=1, no hazards → IDLE outputs during reset; `pc_write_o`=1, `pc_sel_o`=00 from the second cycle.
- `ex_memread_i`=1, `ex_rt_i`=5, `id_rs_i`=5 → one cycle with `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1.
  - Same stimulus with `ex_rt_i`=0 → no stall.
- `id_jump_i`=1 and `id_branch_taken_i`=1 together → `pc_sel_o`=10, `ifid_flush_o`=1.
  - Add loaduse in the same cycle → stall with no flush.
- `dmem_req_i`=1, ack after 3 cycles → `pipe_hold_o`=1 for 3 cycles, normal outputs in the ack cycle.
- `MEM_TIMEOUT`=4, `dmem_req_i` held with no ack → HALT and `err_o`=1 after 4 cycles; `rst_i` → back to IDLE with `err_o`=0.
- With `PIPELINE_CTRL_STALL_CNT_EN`: 1 load-use stall + 3 memory-wait cycles → `stall_cnt_o`=4.
